rf_level_stack: RTL and testbench
=================================

Name: rf_level_stack

Overview:
- Banked RISC-V register file for the preemptive interrupt core: one private register bank per priority level, plus a shared bank for registers selected by a parameter mask (sp by default).
- Unlike the fixed-level register file, this block tracks the active level itself through an internal push/pop level stack.
- On each push (interrupt entry) the block zero-scrubs the incoming bank and seeds its ra.
- Sits between decode (read ports), writeback (write port) and the interrupt controller (push/pop).

Parameters:
- DataWidth, 32, register width.
- NumRegs, 32, registers per bank; IndexWidth = $clog2(NumRegs).
- NumLevels, 8, priority levels and private banks; LevelWidth = $clog2(NumLevels).
- SharedMask, 'h4, bit i set means register i lives in the shared bank. Bit 0 and bit RaIndex must be 0; elaboration error otherwise.
- RaIndex, 1, register index seeded on push.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- writeEn  in  1  register write strobe.
- writeAddr  in  IndexWidth  write index.
- writeData  in  DataWidth  write data.
- readAddr1  in  IndexWidth  read index, port 1.
- readAddr2  in  IndexWidth  read index, port 2.
- readData1  out  DataWidth  combinational read data, port 1.
- readData2  out  DataWidth  combinational read data, port 2.
- readRa  out  DataWidth  ra of the current level (combinational).
- push  in  1  enter the level given by pushLevel.
- pushLevel  in  LevelWidth  target level.
- pushRa  in  DataWidth  value seeded into ra of the new level.
- pop  in  1  return to the preempted level.
- level  out  LevelWidth  current level (registered).
- depth  out  LevelWidth+1  number of stacked levels (registered).
- err  out  1  one-cycle pulse when a push/pop request is rejected.

Behaviour:
- Reset (clk edge with reset=1):
  - level=0, depth=0, err=0.
  - All valid bits cleared in every bank, including the shared bank, so every read returns 0.
  - Reset overrides any push, pop or write in the same cycle.
- Storage:
  - Data array regs[NumLevels][NumRegs] plus a valid bit per entry. The shared bank is regs[0] restricted to SharedMask indices.
  - Bank selection: bank(r) = SharedMask[r] ? 0 : level.
  - Level-0 private registers and shared registers share bank 0 without conflict, since the index sets are disjoint.
- Write:
  - On a clk edge with writeEn=1 and writeAddr!=0: regs[bank(writeAddr)][writeAddr] <= writeData and its valid bit is set.
  - Writes to x0 are dropped.
  - The bank is chosen using the pre-edge level.
- Read, per port, combinational with priority:
  1. addr==0 gives 0.
  2. writeEn and writeAddr==addr give writeData (write-through bypass).
  3. valid gives regs[bank(addr)][addr].
  4. Otherwise 0.
- readRa follows the same rules for RaIndex, including the bypass.
- Push is accepted when push=1, pop=0, pushLevel>level and depth<NumLevels-1. At the edge:
  - The current level is pushed onto the internal stack; level <= pushLevel; depth++.
  - All valid bits of bank pushLevel are cleared, except RaIndex, which is written with pushRa and marked valid.
  - A same-cycle writeEn targets the old level's bank, or the shared bank.
- Pop is accepted when pop=1, push=0 and depth>0. At the edge:
  - level <= top of stack; depth--.
  - The popped bank's contents are left untouched (scrubbed on its next push).
- Rejections:
  - A rejected push (pushLevel<=level, or stack full), a rejected pop (depth==0), or push and pop both asserted: state unchanged, err=1 for exactly the next cycle.
  - The register write, if any, still occurs.
- Back-to-back push/pop on consecutive cycles is supported with no bubbles. The level stack is NumLevels-1 entries of LevelWidth bits.

Test Plan:
- Reset, then read x0..x31 at level 0 -> all 0. Write x0='hdeadbeef -> x0 still reads 0.
- Level 0: write x2='h12345678 and x3='h1111. Push level 3, pushRa='hffffff00 -> level=3, depth=1. Read x2='h12345678, x3=0, readRa='hffffff00.
- Level 3: write x3='h2222 in the same cycle as reading x3 -> readData1='h2222 (bypass). Pop -> level=0, x3='h1111, x2='h12345678.
- Push level 5 with writeEn x5='haaaa in the same edge -> after the edge x5 reads 0 at level 5; after pop, x5 reads 'haaaa at level 0.
- Push 2, then push 2 again -> err pulses 1 cycle; level=2, depth=1. Pop twice -> second pop gives err; level=0, depth=0.
- NumLevels=4: push 1, 2, 3 -> depth=3 at level 3. Next push is rejected by both its level check and the full check; err=1. Push and pop asserted together -> err, state unchanged. Reset mid-stack -> level=0, depth=0, reads 0.

Source files
------------

// File: rtl/rf_level_stack.sv
// Banked register file with an internal level stack: one private bank per
// priority level, a shared bank for SharedMask registers, scrub-and-seed on push.
module rf_level_stack #(
  parameter int DataWidth = 32,
  parameter int NumRegs = 32,
  parameter int NumLevels = 8,
  parameter logic [NumRegs-1:0] SharedMask = 'h4,
  parameter int RaIndex = 1,
  localparam int IndexWidth = $clog2(NumRegs),
  localparam int LevelWidth = $clog2(NumLevels)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEn,
  input  logic [IndexWidth-1:0] writeAddr,
  input  logic [DataWidth-1:0]  writeData,
  input  logic [IndexWidth-1:0] readAddr1,
  input  logic [IndexWidth-1:0] readAddr2,
  output logic [DataWidth-1:0]  readData1,
  output logic [DataWidth-1:0]  readData2,
  output logic [DataWidth-1:0]  readRa,
  input  logic                  push,
  input  logic [LevelWidth-1:0] pushLevel,
  input  logic [DataWidth-1:0]  pushRa,
  input  logic                  pop,
  output logic [LevelWidth-1:0] level,
  output logic [LevelWidth:0]   depth,
  output logic                  err
);

  localparam logic [LevelWidth:0]   StackEntries = (LevelWidth + 1)'(NumLevels - 1);
  localparam logic [IndexWidth-1:0] RaAddr       = IndexWidth'(RaIndex);

  // x0 and ra must stay private: x0 is hardwired, ra is seeded per level.
  if (SharedMask[0] || SharedMask[RaIndex]) begin : gBadMask
    $error("rf_level_stack: SharedMask must not include x0 or RaIndex");
  end

  logic [DataWidth-1:0]               regs [NumLevels][NumRegs];
  logic [NumLevels-1:0][NumRegs-1:0]  valid;
  logic [LevelWidth-1:0]              levelStack [0:NumLevels-2];

  logic                  pushOk;
  logic                  popOk;
  logic                  reqBad;
  logic                  writeHit;
  logic [LevelWidth-1:0] writeBank;
  logic [LevelWidth-1:0] stackIdx;
  logic [LevelWidth-1:0] topIdx;

  assign pushOk    = push && !pop && (pushLevel > level) && (depth < StackEntries);
  assign popOk     = pop && !push && (depth != '0);
  assign reqBad    = (push || pop) && !pushOk && !popOk;
  assign writeHit  = writeEn && (writeAddr != '0);
  assign writeBank = SharedMask[writeAddr] ? '0 : level;
  assign stackIdx  = depth[LevelWidth-1:0];
  assign topIdx    = LevelWidth'(depth - 1'b1);

  // Priority: x0, write-through bypass, stored value if valid, else zero.
  function automatic logic [DataWidth-1:0] readReg(input logic [IndexWidth-1:0] addr);
    logic [LevelWidth-1:0] bank;
    bank = SharedMask[addr] ? '0 : level;
    if (addr == '0)                        return '0;
    else if (writeEn && writeAddr == addr) return writeData;
    else if (valid[bank][addr])            return regs[bank][addr];
    else                                   return '0;
  endfunction

  always_comb begin
    readData1 = readReg(readAddr1);
    readData2 = readReg(readAddr2);
    readRa    = readReg(RaAddr);
  end

  // NOTE: data array and stack carry no reset; the valid bits alone define
  // what reads return, which keeps the storage a plain RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (writeHit) regs[writeBank][writeAddr] <= writeData;
      if (pushOk) begin
        regs[pushLevel][RaIndex] <= pushRa;
        levelStack[stackIdx]     <= level;
      end
    end
  end

  // A same-edge write lands in the old level's bank (or bank 0), never in
  // pushLevel's bank, since pushLevel is strictly above the current level.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      depth <= '0;
      err   <= 1'b0;
      valid <= '0;
    end else begin
      err <= reqBad;
      if (writeHit) valid[writeBank][writeAddr] <= 1'b1;
      if (pushOk) begin
        level                   <= pushLevel;
        depth                   <= depth + 1'b1;
        valid[pushLevel]        <= '0;
        valid[pushLevel][RaIndex] <= 1'b1;
      end else if (popOk) begin
        level <= levelStack[topIdx];
        depth <= depth - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_level_stack.sv
// Directed bench for rf_level_stack: default 8-level instance plus a 4-level
// instance for stack-full behaviour.
module tb_rf_level_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        writeEn;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [4:0]  readAddr1;
  logic [4:0]  readAddr2;
  logic        push;
  logic [2:0]  pushLevel;
  logic [31:0] pushRa;
  logic        pop;

  logic [31:0] mRd1, mRd2, mRa;
  logic [2:0]  mLevel;
  logic [3:0]  mDepth;
  logic        mErr;

  logic [31:0] sRd1, sRd2, sRa;
  logic [1:0]  sLevel;
  logic [2:0]  sDepth;
  logic        sErr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rf_level_stack dutMain (
    .clk(clk), .reset(reset),
    .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(mRd1), .readData2(mRd2), .readRa(mRa),
    .push(push), .pushLevel(pushLevel), .pushRa(pushRa), .pop(pop),
    .level(mLevel), .depth(mDepth), .err(mErr)
  );

  rf_level_stack #(.NumLevels(4)) dutSmall (
    .clk(clk), .reset(reset),
    .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(sRd1), .readData2(sRd2), .readRa(sRa),
    .push(push), .pushLevel(pushLevel[1:0]), .pushRa(pushRa), .pop(pop),
    .level(sLevel), .depth(sDepth), .err(sErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeEn = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [31:0] d);
    writeEn = 1'b1; writeAddr = a; writeData = d;
    tick();
    writeEn = 1'b0;
  endtask

  task automatic doPush(input logic [2:0] lv, input logic [31:0] ra);
    push = 1'b1; pushLevel = lv; pushRa = ra;
    tick();
    push = 1'b0;
  endtask

  task automatic doPop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [4:0] a, input logic [31:0] exp);
    readAddr1 = a;
    #1;
    check(tag, mRd1, exp);
  endtask

  initial begin
    idle();
    reset = 1'b1; writeAddr = '0; writeData = '0; readAddr1 = '0; readAddr2 = '0;
    pushLevel = '0; pushRa = '0;
    #2;
    tick();
    reset = 1'b0;
    check("reset level", 32'(mLevel), 0);
    check("reset depth", 32'(mDepth), 0);
    check("reset err", 32'(mErr), 0);

    for (int i = 0; i < 32; i++) begin
      readAddr1 = 5'(i); readAddr2 = 5'(31 - i);
      #1;
      check("reset rd1", mRd1, 0);
      check("reset rd2", mRd2, 0);
    end
    check("reset ra", mRa, 0);

    // x0 ignores writes and bypass
    writeEn = 1'b1; writeAddr = 5'd0; writeData = 32'hdeadbeef; readAddr1 = 5'd0;
    #1;
    check("x0 bypass", mRd1, 0);
    tick();
    writeEn = 1'b0;
    readCheck("x0 stored", 5'd0, 0);

    doWrite(5'd2, 32'h12345678);
    doWrite(5'd3, 32'h1111);
    doPush(3'd3, 32'hffffff00);
    check("push3 level", 32'(mLevel), 3);
    check("push3 depth", 32'(mDepth), 1);
    check("push3 err", 32'(mErr), 0);
    readCheck("lv3 shared x2", 5'd2, 32'h12345678);
    readCheck("lv3 private x3", 5'd3, 0);
    check("lv3 ra", mRa, 32'hffffff00);

    writeEn = 1'b1; writeAddr = 5'd3; writeData = 32'h2222; readAddr1 = 5'd3;
    #1;
    check("lv3 bypass x3", mRd1, 32'h2222);
    tick();
    writeEn = 1'b0;
    readCheck("lv3 stored x3", 5'd3, 32'h2222);

    doPop();
    check("pop level", 32'(mLevel), 0);
    check("pop depth", 32'(mDepth), 0);
    readCheck("lv0 x3", 5'd3, 32'h1111);
    readCheck("lv0 x2", 5'd2, 32'h12345678);
    check("lv0 ra", mRa, 0);

    // Same-edge write goes to the old level's bank
    writeEn = 1'b1; writeAddr = 5'd5; writeData = 32'haaaa;
    doPush(3'd5, 32'h55);
    writeEn = 1'b0;
    check("push5 level", 32'(mLevel), 5);
    readCheck("lv5 x5", 5'd5, 0);
    check("lv5 ra", mRa, 32'h55);
    doPop();
    readCheck("lv0 x5", 5'd5, 32'haaaa);

    // Re-entering level 3 scrubs the stale x3
    doPush(3'd3, 32'h33);
    readCheck("lv3 rescrub x3", 5'd3, 0);
    check("lv3 reseed ra", mRa, 32'h33);
    doPop();

    // Rejections
    doPush(3'd2, 32'h0);
    check("push2 err", 32'(mErr), 0);
    doPush(3'd2, 32'h0);
    check("repush err", 32'(mErr), 1);
    check("repush level", 32'(mLevel), 2);
    check("repush depth", 32'(mDepth), 1);
    doPop();
    check("pop1 err", 32'(mErr), 0);
    check("pop1 level", 32'(mLevel), 0);
    doPop();
    check("pop2 err", 32'(mErr), 1);
    check("pop2 level", 32'(mLevel), 0);
    check("pop2 depth", 32'(mDepth), 0);
    tick();
    check("err one cycle", 32'(mErr), 0);

    // 4-level instance: fill the stack
    reset = 1'b1;
    tick();
    reset = 1'b0;
    doPush(3'd1, 32'h1);
    doPush(3'd2, 32'h2);
    doPush(3'd3, 32'h3);
    check("small level", 32'(sLevel), 3);
    check("small depth", 32'(sDepth), 3);
    check("small err", 32'(sErr), 0);
    check("small ra", sRa, 32'h3);

    writeEn = 1'b1; writeAddr = 5'd4; writeData = 32'h77;
    doPush(3'd3, 32'h99);
    writeEn = 1'b0;
    check("full err", 32'(sErr), 1);
    check("full level", 32'(sLevel), 3);
    check("full depth", 32'(sDepth), 3);
    check("full ra kept", sRa, 32'h3);
    readAddr1 = 5'd4;
    #1;
    check("rejected write lands", sRd1, 32'h77);

    push = 1'b1; pop = 1'b1; pushLevel = 3'd0;
    tick();
    idle();
    check("both err", 32'(sErr), 1);
    check("both level", 32'(sLevel), 3);
    check("both depth", 32'(sDepth), 3);

    doPop();
    check("small pop level", 32'(sLevel), 2);
    check("small pop depth", 32'(sDepth), 2);
    check("small pop err", 32'(sErr), 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    readAddr1 = 5'd4; readAddr2 = 5'd1;
    #1;
    check("mid reset level", 32'(sLevel), 0);
    check("mid reset depth", 32'(sDepth), 0);
    check("mid reset rd1", sRd1, 0);
    check("mid reset rd2", sRd2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
